up_param_core: RTL

UP_PARAM_CORE -- requirements
Module: up_param_core

---
 rtl/up_param_core.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/up_param_core.sv
// Parameterised multi-cycle accumulator microcontroller core.
// FETCH -> EXEC (-> MEM for LD/ADDM) -> FETCH, with a small hardware call stack.
module up_param_core #(
    parameter int DW = 4,
    parameter int AW = 12,
    parameter int SD = 4
) (
    input  logic          clk0,
    input  logic          reset0,
    input  logic          run,
    output logic [AW-1:0] rom_addr,
    input  logic [AW+3:0] rom_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic          ram_re,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    input  logic [DW-1:0] in_port,
    output logic [DW-1:0] out_port,
    output logic [DW-1:0] acc,
    output logic          c_flag,
    output logic          z_flag,
    output logic [1:0]    state,
    output logic          stk_err
);

    localparam int SPW = $clog2(SD + 1);

    localparam logic [3:0] OP_JC    = 4'h0;
    localparam logic [3:0] OP_JNC   = 4'h1;
    localparam logic [3:0] OP_CMPI  = 4'h2;
    localparam logic [3:0] OP_NANDI = 4'h3;
    localparam logic [3:0] OP_LIT   = 4'h4;
    localparam logic [3:0] OP_IN    = 4'h5;
    localparam logic [3:0] OP_LD    = 4'h6;
    localparam logic [3:0] OP_ST    = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JNZ   = 4'h9;
    localparam logic [3:0] OP_ADDI  = 4'hA;
    localparam logic [3:0] OP_ADDM  = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_OUT   = 4'hD;
    localparam logic [3:0] OP_CALL  = 4'hE;
    localparam logic [3:0] OP_RET   = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_MEM   = 2'b10
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   pc_reg, pc_next;
    logic [AW+3:0]   ir_reg, ir_next;
    logic [DW-1:0]   acc_reg, acc_next;
    logic            c_reg, c_next;
    logic            z_reg, z_next;
    logic [SPW-1:0]  sp_reg, sp_next;
    logic [DW-1:0]   out_reg, out_next;
    logic            err_reg, err_next;
    logic            push;

    logic [3:0]      opcode;
    logic [AW-1:0]   operand;
    logic [DW-1:0]   imm;
    logic [DW:0]     add_imm;
    logic [DW:0]     sub_imm;
    logic [DW:0]     add_mem;
    logic [DW-1:0]   nand_res;
    logic            stk_full;
    logic            stk_empty;

    logic [AW-1:0]   stack_mem [SD];
    logic [SD-1:0]   push_hit;
    logic [SD-1:0]   pop_hit;
    logic [AW-1:0]   pop_data;

    assign opcode  = ir_reg[AW+3:AW];
    assign operand = ir_reg[AW-1:0];

    // Immediate is the low DW bits of the operand, zero-extended if the operand is narrower.
    generate
        if (DW <= AW) begin : g_imm_slice
            assign imm = operand[DW-1:0];
        end else begin : g_imm_ext
            assign imm = {{(DW-AW){1'b0}}, operand};
        end
    endgenerate

    // One extra bit on every operation carries the carry / unsigned borrow.
    assign add_imm  = {1'b0, acc_reg} + {1'b0, imm};
    assign sub_imm  = {1'b0, acc_reg} - {1'b0, imm};
    assign add_mem  = {1'b0, acc_reg} + {1'b0, ram_rdata};
    assign nand_res = ~(acc_reg & imm);

    assign stk_full  = (sp_reg == SPW'(SD));
    assign stk_empty = (sp_reg == '0);

    // Slot gi is written when sp points at it, and read back when sp sits one above it.
    generate
        for (genvar gi = 0; gi < SD; gi++) begin : g_stack_sel
            assign push_hit[gi] = (sp_reg == SPW'(gi));
            assign pop_hit[gi]  = (sp_reg == SPW'(gi + 1));
        end
    endgenerate

    always_comb begin
        pop_data = '0;
        for (int i = 0; i < SD; i++) begin
            if (pop_hit[i]) begin
                pop_data = stack_mem[i];
            end
        end
    end

    always_ff @(posedge clk0) begin
        for (int i = 0; i < SD; i++) begin
            if (push && push_hit[i]) begin
                stack_mem[i] <= pc_reg;
            end
        end
    end

    always_ff @(posedge clk0 or posedge reset0) begin
        if (reset0) begin
            state_reg <= S_FETCH;
            pc_reg    <= '0;
            ir_reg    <= '0;
            acc_reg   <= '0;
            c_reg     <= 1'b0;
            z_reg     <= 1'b0;
            sp_reg    <= '0;
            out_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            acc_reg   <= acc_next;
            c_reg     <= c_next;
            z_reg     <= z_next;
            sp_reg    <= sp_next;
            out_reg   <= out_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        acc_next   = acc_reg;
        c_next     = c_reg;
        z_next     = z_reg;
        sp_next    = sp_reg;
        out_next   = out_reg;
        err_next   = err_reg;
        push       = 1'b0;

        case (state_reg)
            S_FETCH: begin
                if (run) begin
                    ir_next    = rom_data;
                    pc_next    = pc_reg + AW'(1);
                    state_next = S_EXEC;
                end
            end

            S_EXEC: begin
                state_next = S_FETCH;
                case (opcode)
                    OP_JC:    if (c_reg)  pc_next = operand;
                    OP_JNC:   if (!c_reg) pc_next = operand;
                    OP_CMPI: begin
                        c_next = sub_imm[DW];
                        z_next = (sub_imm[DW-1:0] == '0);
                    end
                    OP_NANDI: begin
                        acc_next = nand_res;
                        c_next   = 1'b0;
                        z_next   = (nand_res == '0);
                    end
                    OP_LIT:   acc_next = imm;
                    OP_IN:    acc_next = in_port;
                    OP_LD:    state_next = S_MEM;
                    OP_ST:    ;
                    OP_JZ:    if (z_reg)  pc_next = operand;
                    OP_JNZ:   if (!z_reg) pc_next = operand;
                    OP_ADDI: begin
                        acc_next = add_imm[DW-1:0];
                        c_next   = add_imm[DW];
                        z_next   = (add_imm[DW-1:0] == '0);
                    end
                    OP_ADDM:  state_next = S_MEM;
                    OP_JMP:   pc_next = operand;
                    OP_OUT:   out_next = acc_reg;
                    OP_CALL: begin
                        if (stk_full) begin
                            err_next = 1'b1;
                        end else begin
                            push    = 1'b1;
                            sp_next = sp_reg + SPW'(1);
                            pc_next = operand;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            err_next = 1'b1;
                        end else begin
                            sp_next = sp_reg - SPW'(1);
                            pc_next = pop_data;
                        end
                    end
                    default: ;
                endcase
            end

            S_MEM: begin
                state_next = S_FETCH;
                if (opcode == OP_ADDM) begin
                    acc_next = add_mem[DW-1:0];
                    c_next   = add_mem[DW];
                    z_next   = (add_mem[DW-1:0] == '0);
                end else begin
                    acc_next = ram_rdata;
                end
            end

            default: state_next = S_FETCH;
        endcase
    end

    // Strobes decode straight from state, so reset drops them immediately.
    assign ram_we    = (state_reg == S_EXEC) && (opcode == OP_ST);
    assign ram_re    = (state_reg == S_EXEC) && ((opcode == OP_LD) || (opcode == OP_ADDM));
    assign rom_addr  = pc_reg;
    assign ram_addr  = operand;
    assign ram_wdata = acc_reg;
    assign out_port  = out_reg;
    assign acc       = acc_reg;
    assign c_flag    = c_reg;
    assign z_flag    = z_reg;
    assign state     = state_reg;
    assign stk_err   = err_reg;

endmodule
